// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: owner tags, the
// address-phase bundle and the full-word byte-enable constant.
package mem_arbiter_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } mem_owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [3:0] MEM_BE_WORD = 4'hF;

  // Instruction fetches are always full-word reads with no write data.
  function automatic mem_req_t if_fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = MEM_BE_WORD;
    r.addr  = addr;
    r.wdata = 32'h0;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// Small FIFO of owner tags: one entry per granted-but-unanswered memory
// transaction, so responses can be routed back in order.
module mem_arbiter_owner_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  mem_owner_e       push_owner_i,
  input  logic             pop_i,
  output mem_owner_e       head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_owner_e       slot_q [DEPTH];
  mem_owner_e       slot_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push_i & (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i & (count_q != '0);
  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;

  // Write the pushed tag, advance pointers and track occupancy.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      slot_d[wr_ptr_q] = push_owner_i;
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; reset discards every in-flight owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= OWNER_IF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-way memory port arbiter (instruction fetch vs load/store).
// Address phases are arbitrated combinationally, the choice is locked while
// the memory stalls, and an owner FIFO routes in-order responses back.
// Build option: define MEM_ARBITER_RR_EN for round-robin selection instead
// of LS priority with an IF starvation override.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] fifo_count;
  mem_owner_e       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             grant;
  logic             pop;
  mem_owner_e       sel;
  logic             lock_live;
  mem_req_t         req_fields;

  logic             lock_q, lock_d;
  mem_owner_e       lock_owner_q, lock_owner_d;
  logic             err_q, err_d;

`ifdef MEM_ARBITER_RR_EN
  mem_owner_e       last_q, last_d;
`else
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
`endif

  assign fifo_full  = (fifo_count == CNT_W'(MAX_OUTST));
  assign fifo_empty = (fifo_count == '0);

  // A lock only matters while its owner is still holding its request.
  assign lock_live = lock_q & ((lock_owner_q == OWNER_IF) ? if_req_i : ls_req_i);

  // Pick the owner of this cycle's address phase.
  always_comb begin
    sel = OWNER_LS;
    if (lock_live) begin
      sel = lock_owner_q;
    end else begin
`ifdef MEM_ARBITER_RR_EN
      if (if_req_i && ls_req_i) begin
        sel = (last_q == OWNER_IF) ? OWNER_LS : OWNER_IF;
      end else if (if_req_i) begin
        sel = OWNER_IF;
      end
`else
      if (ls_req_i && !(if_req_i && (starve_q == STARVE_W'(STARVE_LIMIT)))) begin
        sel = OWNER_LS;
      end else if (if_req_i) begin
        sel = OWNER_IF;
      end
`endif
    end
  end

  // Drive the memory address phase and the per-requester grants.
  always_comb begin
    mem_req_o  = (if_req_i | ls_req_i) & ~fifo_full;
    req_fields = '0;
    if (mem_req_o) begin
      if (sel == OWNER_IF) begin
        req_fields = if_fetch_req(if_addr_i);
      end else begin
        req_fields.we    = ls_we_i;
        req_fields.be    = ls_be_i;
        req_fields.addr  = ls_addr_i;
        req_fields.wdata = ls_wdata_i;
      end
    end
    grant    = mem_req_o & mem_gnt_i;
    if_gnt_o = grant & (sel == OWNER_IF);
    ls_gnt_o = grant & (sel == OWNER_LS);
  end

  assign mem_we_o    = req_fields.we;
  assign mem_be_o    = req_fields.be;
  assign mem_addr_o  = req_fields.addr;
  assign mem_wdata_o = req_fields.wdata;

  // Route each response to whoever owns the oldest outstanding transaction.
  always_comb begin
    pop         = mem_rvalid_i & ~fifo_empty;
    if_rvalid_o = pop & (fifo_head == OWNER_IF);
    ls_rvalid_o = pop & (fifo_head == OWNER_LS);
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
    err_d       = err_q | (mem_rvalid_i & fifo_empty);
  end

  assign err_o = err_q;

  // Hold the selection across memory stalls; release it once granted.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (grant) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d       = 1'b1;
      lock_owner_d = sel;
    end else if (!lock_live) begin
      lock_d = 1'b0;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Remember who won last so the other side wins the next tie.
  always_comb begin
    last_d = last_q;
    if (if_gnt_o) last_d = OWNER_IF;
    else if (ls_gnt_o) last_d = OWNER_LS;
  end
`else
  // Count consecutive IF losses to LS, saturating at the override threshold.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (ls_gnt_o && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end
`endif

  // Arbiter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_IF;
      err_q        <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= OWNER_IF;
`else
      starve_q     <= '0;
`endif
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= last_d;
`else
      starve_q     <= starve_d;
`endif
    end
  end

  mem_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (grant),
    .push_owner_i (sel),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected response owners are queued
// as grants are expected and popped when the memory returns data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAX_OUTST    = 2;
  localparam int STARVE_LIMIT = 4;
  localparam logic [3:0] LS_BE = 4'h3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int         checkCount = 0;
  int         errorCount = 0;
  logic       expErr = 1'b0;
  mem_owner_e respQ[$];

  mem_arbiter #(
    .MAX_OUTST    (MAX_OUTST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .ls_req_i     (ls_req_i),
    .ls_we_i      (ls_we_i),
    .ls_be_i      (ls_be_i),
    .ls_addr_i    (ls_addr_i),
    .ls_wdata_i   (ls_wdata_i),
    .ls_gnt_o     (ls_gnt_o),
    .ls_rvalid_o  (ls_rvalid_o),
    .ls_rdata_o   (ls_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Safety net in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive inputs after the falling edge, check mid-cycle.
  // expSel: 0 none, 1 IF, 2 LS (the owner expected on the memory port).
  task automatic applyStimulus(input string tag,
                               input logic ifReq, input logic [31:0] ifAddr,
                               input logic lsReq, input logic lsWe,
                               input logic [31:0] lsAddr, input logic [31:0] lsWdata,
                               input logic gnt, input logic rvalid,
                               input logic [31:0] rdata,
                               input logic expReq, input int expSel);
    mem_owner_e expOwner;
    @(negedge clk_i);
    if_req_i     = ifReq;
    if_addr_i    = ifAddr;
    ls_req_i     = lsReq;
    ls_we_i      = lsWe;
    ls_be_i      = LS_BE;
    ls_addr_i    = lsAddr;
    ls_wdata_i   = lsWdata;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rvalid;
    mem_rdata_i  = rdata;
    #1;
    checkOutput($sformatf("%s err", tag), 32'(err_o), 32'(expErr));
    checkOutput($sformatf("%s mem_req", tag), 32'(mem_req_o), 32'(expReq));
    if (rvalid) begin
      if (respQ.size() > 0) begin
        expOwner = respQ.pop_front();
        checkOutput($sformatf("%s if_rvalid", tag), 32'(if_rvalid_o), 32'(expOwner == OWNER_IF));
        checkOutput($sformatf("%s ls_rvalid", tag), 32'(ls_rvalid_o), 32'(expOwner == OWNER_LS));
        checkOutput($sformatf("%s rdata", tag),
                    (expOwner == OWNER_IF) ? if_rdata_o : ls_rdata_o, rdata);
      end else begin
        checkOutput($sformatf("%s stray rvalid", tag), 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
        expErr = 1'b1;
      end
    end else begin
      checkOutput($sformatf("%s no rvalid", tag), 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    end
    if (expReq) begin
      if (expSel == 1) begin
        checkOutput($sformatf("%s addr", tag), mem_addr_o, ifAddr);
        checkOutput($sformatf("%s we/be", tag), 32'({mem_we_o, mem_be_o}), 32'({1'b0, 4'hF}));
        checkOutput($sformatf("%s wdata", tag), mem_wdata_o, 32'h0);
      end else begin
        checkOutput($sformatf("%s addr", tag), mem_addr_o, lsAddr);
        checkOutput($sformatf("%s we/be", tag), 32'({mem_we_o, mem_be_o}), 32'({lsWe, LS_BE}));
        checkOutput($sformatf("%s wdata", tag), mem_wdata_o, lsWdata);
      end
      checkOutput($sformatf("%s if_gnt", tag), 32'(if_gnt_o), 32'(gnt && (expSel == 1)));
      checkOutput($sformatf("%s ls_gnt", tag), 32'(ls_gnt_o), 32'(gnt && (expSel == 2)));
      if (gnt) respQ.push_back((expSel == 1) ? OWNER_IF : OWNER_LS);
    end else begin
      checkOutput($sformatf("%s idle be", tag), 32'(mem_be_o), 32'd0);
      checkOutput($sformatf("%s idle gnt", tag), 32'({if_gnt_o, ls_gnt_o}), 32'd0);
    end
  endtask

  initial begin
    int expSel;
    rst_i        = 1'b1;
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    ls_req_i     = 1'b0;
    ls_we_i      = 1'b0;
    ls_be_i      = '0;
    ls_addr_i    = '0;
    ls_wdata_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #12;
    checkOutput("reset mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("reset gnt", 32'({if_gnt_o, ls_gnt_o}), 32'd0);
    checkOutput("reset rvalid", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("reset be", 32'(mem_be_o), 32'd0);
    checkOutput("reset addr", mem_addr_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] contention / starvation sequence");
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_RR_EN
      expSel = (i % 2 == 0) ? 2 : 1;
`else
      expSel = (i == 4) ? 1 : 2;
`endif
      applyStimulus($sformatf("starve%0d", i), 1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0,
                    32'h800 + 32'(i * 4), 32'h0, 1'b1, (i > 0), 32'h1000 + 32'(i),
                    1'b1, expSel);
    end
    applyStimulus("starve drain", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,
                  32'h1006, 1'b0, 0);

    $display("[TB] LS write alone");
    applyStimulus("lsw c0", 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0,
                  32'h0, 1'b1, 2);
    applyStimulus("lsw c1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,
                  32'hCAFE0001, 1'b0, 0);

    $display("[TB] IF stalled, LS arrives, lock holds");
    applyStimulus("lock c0", 1'b1, 32'h200, 1'b0, 1'b0, 32'h300, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus("lock c1", 1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus("lock c2", 1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus("lock c3", 1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus("lock c4", 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h5, 1'b1, 1'b1, 32'h33, 1'b1, 2);
    applyStimulus("lock c5", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0, 0);

    $display("[TB] outstanding limit");
    applyStimulus("full c0", 1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("full c1", 1'b0, 32'h0, 1'b1, 1'b0, 32'hA04, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("full c2", 1'b0, 32'h0, 1'b1, 1'b0, 32'hA08, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("full c3", 1'b0, 32'h0, 1'b1, 1'b0, 32'hA08, 32'h0, 1'b1, 1'b1, 32'h51, 1'b0, 0);
    applyStimulus("full c4", 1'b0, 32'h0, 1'b1, 1'b0, 32'hA08, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("full c5", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h52, 1'b0, 0);
    applyStimulus("full c6", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h53, 1'b0, 0);

    $display("[TB] in-order response routing");
    applyStimulus("order c0", 1'b1, 32'hB00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus("order c1", 1'b0, 32'h0, 1'b1, 1'b0, 32'hC00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("order c2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11, 1'b0, 0);
    applyStimulus("order c3", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22, 1'b0, 0);

    $display("[TB] stray response and sticky error");
    applyStimulus("stray c0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEE, 1'b0, 0);
    applyStimulus("stray c1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("stray c2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0);

    $display("[TB] reset with a transaction in flight and a lock held");
    applyStimulus("rst c0", 1'b0, 32'h0, 1'b1, 1'b0, 32'hD00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("rst c1", 1'b1, 32'hE00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async reset err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    expErr = 1'b0;
    respQ.delete();
    applyStimulus("post c0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66, 1'b0, 0);
    applyStimulus("post c1", 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h9, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus("post c2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b0, 0);
    applyStimulus("post c3", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
